// File: rtl/queue_pkg.sv
// Shared definitions for the SRAM-backed byte queue (producer and consumer sides).
package queue_pkg;

   localparam int DATA_W       = 8;
   localparam int QUEUE_DEPTH  = 1024;
   localparam int QUEUE_ADDR_W = 10;
   localparam int RD_LATENCY   = 2;
   localparam int SKID_DEPTH   = 4;

   // Number of set bits; used to turn the pending-read pipe into an in-flight count.
   function automatic int count_ones(input logic [7:0] bits);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + int'(bits[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/queue_drain_skid.sv
// Small register FIFO that catches bytes returning from the queue SRAM and
// presents the oldest one to the downstream stream. Pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two.
module queue_drain_skid #(
   parameter int  DATA_W = 8,
   parameter int  DEPTH  = 4,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic [OCC_W-1:0]  occ_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Guarded push/pop: a push into a full buffer is only taken when a pop frees the slot.
   always_comb begin
      do_pop   = pop_i & (occ_q != '0);
      do_push  = push_i & ((occ_q != OCC_W'(DEPTH)) | do_pop);
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d    = occ_q;
      if (do_push && !do_pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!do_push && do_pop) begin
         occ_d = occ_q - 1'b1;
      end
   end

   // Storage, pointers and occupancy; storage is cleared so the output reads 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign data_o = mem_q[rd_ptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/queue_drain.sv
// Consumer side of the SRAM-backed byte queue. Issues pop strobes only while
// buffer credit remains (occupancy + reads still in flight), tracks each strobe
// through a RD_LATENCY-deep pending pipe, and lands returning bytes in a skid
// buffer that feeds a valid/ready stream.
// Optional build macro QUEUE_DRAIN_CNT_EN adds drain_count_o, a wrapping 16-bit
// count of bytes delivered downstream.
module queue_drain
   import queue_pkg::*;
#(
   parameter int DATA_W     = queue_pkg::DATA_W,
   parameter int RD_LATENCY = queue_pkg::RD_LATENCY,
   parameter int SKID_DEPTH = queue_pkg::SKID_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              q_valid_i,
   output logic              q_read_o,
   input  logic [DATA_W-1:0] q_data_i,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   input  logic              m_ready_i,
   output logic              busy_o
`ifdef QUEUE_DRAIN_CNT_EN
   ,
   output logic [15:0]       drain_count_o
`endif
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);

   logic                  q_read_q, q_read_d;
   logic [RD_LATENCY-1:0] pending_q, pending_d;
   logic                  busy_q, busy_d;
   logic                  push, pop, m_valid;
   logic [OCC_W-1:0]      occ;
   logic [DATA_W-1:0]     m_data;
   int                    used_credit;
   int                    occ_next;

   queue_drain_skid #(
      .DATA_W (DATA_W),
      .DEPTH  (SKID_DEPTH)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .data_i (q_data_i),
      .pop_i  (pop),
      .data_o (m_data),
      .occ_o  (occ)
   );

   assign m_valid = (occ != '0);
   assign pop     = m_valid & m_ready_i;
   // The byte for a strobe issued RD_LATENCY cycles ago is on q_data_i now.
   assign push    = pending_q[RD_LATENCY-1];

   // Credit check: the strobe currently on q_read_o is already committed, so it
   // counts against the buffer alongside the pending pipe.
   always_comb begin
      pending_d[0] = q_read_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pending_d[i] = pending_q[i-1];
      end
      used_credit = int'(occ) + count_ones(8'(pending_q)) + int'(q_read_q) - int'(pop);
      q_read_d    = enable_i & q_valid_i & (used_credit < SKID_DEPTH);
      occ_next    = int'(occ) + int'(push) - int'(pop);
      busy_d      = (occ_next != 0) | (pending_d != '0) | q_read_d;
   end

   // Read strobe, pending pipe and busy flag; reset drops any read still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_read_q  <= 1'b0;
         pending_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         q_read_q  <= q_read_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
      end
   end

   assign q_read_o  = q_read_q;
   assign m_valid_o = m_valid;
   assign m_data_o  = m_data;
   assign busy_o    = busy_q;

`ifdef QUEUE_DRAIN_CNT_EN
   logic [15:0] drain_cnt_q, drain_cnt_d;

   assign drain_cnt_d = drain_cnt_q + {15'd0, pop};

   // Delivered-byte counter; wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt_q <= '0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign drain_count_o = drain_cnt_q;
`endif

endmodule

// File: tb/tb_queue_drain.sv
// Bench for queue_drain: a behavioural queue with RD_LATENCY read data, a
// scoreboard of bytes loaded into the queue, and a monitor that pops and
// compares on every downstream handshake.
module tb_queue_drain;
   import queue_pkg::*;

   localparam int L  = RD_LATENCY;
   localparam int DW = DATA_W;

   logic          clk, rst;
   logic          enable_i, q_valid_i, q_read_o, m_valid_o, m_ready_i, busy_o;
   logic [DW-1:0] q_data_i, m_data_o;
`ifdef QUEUE_DRAIN_CNT_EN
   logic [15:0]   drain_count_o;
`endif

   queue_drain dut (
      .clk       (clk),
      .rst       (rst),
      .enable_i  (enable_i),
      .q_valid_i (q_valid_i),
      .q_read_o  (q_read_o),
      .q_data_i  (q_data_i),
      .m_valid_o (m_valid_o),
      .m_data_o  (m_data_o),
      .m_ready_i (m_ready_i),
      .busy_o    (busy_o)
`ifdef QUEUE_DRAIN_CNT_EN
      ,
      .drain_count_o (drain_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] qmem[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] dp[L];
   int            q_cnt;
   logic          rd_s;
   int            checks, errors;
   int            strobes, delivered, cyc, first_cyc, last_cyc;
   logic          hold_chk;
   logic [DW-1:0] held;

   // Queue reports non-empty after accounting for the strobe already on the bus.
   assign q_valid_i = q_read_o ? (q_cnt > 1) : (q_cnt > 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load(input logic [DW-1:0] b);
      qmem.push_back(b);
      exp_q.push_back(b);
      q_cnt++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o || q_read_o) && n < max) begin
         tick(1);
         n++;
      end
      chk("drain_done", 32'(n < max), 32'd1);
   endtask

   // Sample the strobe mid-cycle so the queue model sees the value the DUT drove.
   always @(negedge clk) rd_s = q_read_o;

   // Queue model: pop on each strobe, return the byte RD_LATENCY cycles later.
   always @(posedge clk) begin
      #1;
      cyc++;
      for (int i = L - 1; i > 0; i--) dp[i] = dp[i-1];
      dp[0] = 8'hEE;
      if (rd_s) begin
         strobes++;
         checks++;
         if (q_cnt == 0) begin
            errors++;
            $display("FAIL underflow actual=strobe_on_empty required=no_strobe");
         end else begin
            dp[0] = qmem.pop_front();
            q_cnt--;
         end
      end
      q_data_i = dp[L-1];
   end

   // Monitor: compare every handshake with the scoreboard, and check hold under backpressure.
   always @(negedge clk) begin
      if (rst) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            checks++;
            if (!m_valid_o || m_data_o !== held) begin
               errors++;
               $display("FAIL hold actual=%0b/%0h required=1/%0h", m_valid_o, m_data_o, held);
            end
         end
         if (m_valid_o && m_ready_i) begin
            checks++;
            delivered++;
            last_cyc = cyc;
            if (delivered == 1) first_cyc = cyc;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte actual=%0h required=none", m_data_o);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (m_data_o !== e) begin
                  errors++;
                  $display("FAIL data actual=%0h required=%0h", m_data_o, e);
               end
            end
         end
         hold_chk = m_valid_o && !m_ready_i;
         held     = m_data_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; strobes = 0; delivered = 0; cyc = 0;
      first_cyc = 0; last_cyc = 0; q_cnt = 0; hold_chk = 1'b0; held = '0; rd_s = 1'b0;
      for (int i = 0; i < L; i++) dp[i] = 8'h00;
      q_data_i = '0;
      rst = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0;
      tick(3);
      chk("rst_q_read", 32'(q_read_o), 32'd0);
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_data", 32'(m_data_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      tick(2);

      // Stream 0x10..0x1F at full rate
      strobes = 0; delivered = 0; m_ready_i = 1'b1;
      for (int b = 16'h10; b <= 16'h1F; b++) load(8'(b));
      enable_i = 1'b1;
      wait_drain(200);
      chk("stream_strobes", 32'(strobes), 32'd16);
      chk("stream_count", 32'(delivered), 32'd16);
      chk("stream_rate", 32'(last_cyc - first_cyc), 32'd15);

      // Backpressure: credit stops strobes at the buffer depth
      m_ready_i = 1'b0; strobes = 0; delivered = 0;
      for (int b = 16'h10; b <= 16'h1F; b++) load(8'(b));
      tick(12);
      chk("bp_strobes", 32'(strobes), 32'd4);
      chk("bp_valid", 32'(m_valid_o), 32'd1);
      chk("bp_data", 32'(m_data_o), 32'h10);
      chk("bp_busy", 32'(busy_o), 32'd1);
      m_ready_i = 1'b1;
      wait_drain(200);
      chk("bp_strobes_total", 32'(strobes), 32'd16);
      chk("bp_count", 32'(delivered), 32'd16);

      // Single byte then empty
      strobes = 0; delivered = 0;
      load(8'hA5);
      wait_drain(100);
      chk("one_strobes", 32'(strobes), 32'd1);
      chk("one_count", 32'(delivered), 32'd1);
      chk("one_busy", 32'(busy_o), 32'd0);

      // Enable drop right after the first strobe
      enable_i = 1'b0; tick(2);
      strobes = 0; delivered = 0;
      for (int b = 16'h30; b <= 16'h37; b++) load(8'(b));
      enable_i = 1'b1;
      begin
         int n;
         n = 0;
         while (!q_read_o && n < 20) begin
            tick(1);
            n++;
         end
         chk("en_first_strobe", 32'(q_read_o), 32'd1);
      end
      enable_i = 1'b0;
      tick(10);
      chk("en_strobes", 32'(strobes), 32'd1);
      chk("en_count", 32'(delivered), 32'd1);
      chk("en_busy", 32'(busy_o), 32'd0);
      enable_i = 1'b1;
      wait_drain(200);
      chk("en_strobes_total", 32'(strobes), 32'd8);
      chk("en_count_total", 32'(delivered), 32'd8);

      // Reset mid-burst with reads in flight
      strobes = 0;
      for (int b = 16'h40; b <= 16'h4F; b++) load(8'(b));
      tick(5);
      chk("pre_rst_busy", 32'(busy_o), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_q_read", 32'(q_read_o), 32'd0);
      chk("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("mid_rst_m_data", 32'(m_data_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      qmem.delete(); exp_q.delete(); q_cnt = 0;
      tick(2);
      rst = 1'b0; delivered = 0;
      tick(10);
      chk("post_rst_count", 32'(delivered), 32'd0);
      chk("post_rst_busy", 32'(busy_o), 32'd0);
      load(8'h5A);
      wait_drain(100);
      chk("post_rst_recover", 32'(delivered), 32'd1);

`ifdef QUEUE_DRAIN_CNT_EN
      rst = 1'b1; tick(1); rst = 1'b0; tick(1);
      chk("cnt_reset", 32'(drain_count_o), 32'd0);
      for (int i = 0; i < 300; i++) load(8'(i));
      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 5000) begin
            m_ready_i = 1'($urandom_range(0, 1));
            tick(1);
            n++;
         end
      end
      m_ready_i = 1'b1;
      wait_drain(200);
      chk("cnt_300", 32'(drain_count_o), 32'd300);
      force dut.drain_cnt_q = 16'hFFFF;
      tick(1);
      release dut.drain_cnt_q;
      tick(1);
      load(8'h01); load(8'h02);
      wait_drain(100);
      chk("cnt_wrap", 32'(drain_count_o), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
